mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_align.sv | 71 +++++++
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared encodings for the memory-access stage: write-back field widths,
//   MEM_* operation codes and the bus-transaction FSM states.
//   No ports.
package mem_stage_pkg;

   localparam int RADDR_WIDTH = 5;
   localparam int RDATA_WIDTH = 32;

   typedef enum logic [3:0] {
      MEM_NOP = 4'd0,
      MEM_LB  = 4'd1,
      MEM_LH  = 4'd2,
      MEM_LW  = 4'd3,
      MEM_LBU = 4'd4,
      MEM_LHU = 4'd5,
      MEM_SB  = 4'd6,
      MEM_SH  = 4'd7,
      MEM_SW  = 4'd8
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_stage_align.sv
// mem_align
//   Combinational byte-lane logic for the memory stage: store steering,
//   load byte/half extraction with sign/zero extension, misalignment check.
//   Ports:
//     op_i        memory operation
//     addr_lo_i   byte offset within the word (addr[1:0])
//     st_data_i   store data from the pipeline
//     rdata_i     raw read data from the bus
//     sel_o       byte enables (used for loads and stores)
//     wdata_o     lane-replicated store data
//     ld_data_o   formatted load result
//     misalign_o  access not naturally aligned for its size
//     is_store_o  op is SB/SH/SW
module mem_align
   import mem_stage_pkg::*;
(
   input  mem_op_e     op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o,
   output logic        is_store_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_v = rdata_i[15:8];
         2'd2:    byte_v = rdata_i[23:16];
         2'd3:    byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      sel_o      = 4'b1111;
      wdata_o    = st_data_i;
      ld_data_o  = rdata_i;
      misalign_o = 1'b0;
      is_store_o = 1'b0;
      case (op_i)
         MEM_LB, MEM_LBU, MEM_SB: begin
            sel_o     = 4'b0001 << addr_lo_i;
            wdata_o   = {4{st_data_i[7:0]}};
            ld_data_o = (op_i == MEM_LB) ? {{24{byte_v[7]}}, byte_v}
                                         : {24'd0, byte_v};
         end
         MEM_LH, MEM_LHU, MEM_SH: begin
            sel_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {2{st_data_i[15:0]}};
            ld_data_o  = (op_i == MEM_LH) ? {{16{half_v[15]}}, half_v}
                                          : {16'd0, half_v};
            misalign_o = addr_lo_i[0];
         end
         MEM_LW, MEM_SW: begin
            misalign_o = (addr_lo_i != 2'd0);
         end
         default: begin
         end
      endcase
      is_store_o = (op_i == MEM_SB) || (op_i == MEM_SH) || (op_i == MEM_SW);
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access pipeline stage between EXE/MEM and MEM/WB. Non-memory ops
//   pass write-back fields through; loads/stores run one req/ack data-bus
//   transaction while holding the pipeline with stall_o.
//   Ports:
//     clk_i, rst_n_i          clock, asynchronous active-low reset
//     reg_waddr_i/we_i/wdata_i  write-back fields from EXE/MEM
//     mem_we_i, mem_addr_i, mem_data_i, mem_op_i  memory op from EXE/MEM
//     reg_waddr_o/we_o/wdata_o  write-back fields to MEM/WB
//     stall_o                 freeze upstream, bubble into MEM/WB
//     misalign_o              misaligned-access exception (combinational)
//     bus_err_o               one-cycle pulse on ack timeout
//     dbus_req_o/we_o/addr_o/sel_o/wdata_o  registered data-bus request
//     dbus_rdata_i, dbus_ack_i  data-bus response
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
   input  logic                   mem_we_i,
   input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   input  logic [3:0]             mem_op_i,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [RDATA_WIDTH-1:0] reg_wdata_o,
   output logic                   stall_o,
   output logic                   misalign_o,
   output logic                   bus_err_o,
   output logic                   dbus_req_o,
   output logic                   dbus_we_o,
   output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
   output logic [3:0]             dbus_sel_o,
   output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
   input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
   input  logic                   dbus_ack_i
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);

   mem_state_e             state_q, state_d;
   logic [CW-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]  ld_q;

   mem_op_e                op;
   logic                   memop, misalign, is_store, is_load, go, timeout;
   logic [3:0]             sel;
   logic [31:0]            wdata, ld_data;

   assign op = mem_op_e'(mem_op_i);

   mem_align u_align (
      .op_i       (op),
      .addr_lo_i  (mem_addr_i[1:0]),
      .st_data_i  (mem_data_i),
      .rdata_i    (dbus_rdata_i),
      .sel_o      (sel),
      .wdata_o    (wdata),
      .ld_data_o  (ld_data),
      .misalign_o (misalign),
      .is_store_o (is_store)
   );

   assign memop   = (op != MEM_NOP);
   assign is_load = memop & ~is_store;
   assign go      = memop & ~misalign;
   // Counter holds the number of REQ cycles already spent without ack, so
   // the abort lands after exactly ACK_TIMEOUT cycles of req.
   assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (go) state_d = ST_REQ;
         ST_REQ:  if (dbus_ack_i || timeout) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus request, timeout counter and captured load data
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q        <= '0;
         ld_q         <= '0;
         bus_err_o    <= 1'b0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_sel_o   <= '0;
         dbus_wdata_o <= '0;
      end else begin
         bus_err_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (go) begin
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= is_store;
                  dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  dbus_sel_o   <= sel;
                  dbus_wdata_o <= wdata;
               end
            end
            ST_REQ: begin
               if (dbus_ack_i) begin
                  dbus_req_o <= 1'b0;
                  ld_q       <= ld_data;
               end else if (timeout) begin
                  dbus_req_o <= 1'b0;
                  bus_err_o  <= 1'b1;
                  ld_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      stall_o     = go & (state_q != ST_DONE);
      misalign_o  = memop & misalign;
      reg_waddr_o = reg_waddr_i;
      reg_we_o    = reg_we_i;
      reg_wdata_o = reg_wdata_i;
      if (memop) begin
         reg_we_o = is_load & ~misalign & (state_q == ST_DONE) & reg_we_i;
         if (is_load) reg_wdata_o = ld_q;
      end
   end

   // mem_we_i duplicates the store decode of mem_op_i; kept for port compatibility.
   logic unused_we;
   assign unused_we = mem_we_i;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int TO = 4;
   localparam int OP_NOP = 0, OP_LB = 1, OP_LH = 2, OP_LW = 3, OP_LBU = 4,
                  OP_LHU = 5, OP_SB = 6, OP_SH = 7, OP_SW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  reg_waddr_i = '0;
   logic        reg_we_i = 1'b0;
   logic [31:0] reg_wdata_i = '0;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_i = '0;
   logic [3:0]  mem_op_i = '0;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        stall_o, misalign_o, bus_err_o;
   logic        dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_sel_o;
   logic [31:0] dbus_wdata_o;
   logic [31:0] dbus_rdata_i = '0;
   logic        dbus_ack_i = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACK_TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .reg_waddr_i (reg_waddr_i),
      .reg_we_i    (reg_we_i),
      .reg_wdata_i (reg_wdata_i),
      .mem_we_i    (mem_we_i),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .mem_op_i    (mem_op_i),
      .reg_waddr_o (reg_waddr_o),
      .reg_we_o    (reg_we_o),
      .reg_wdata_o (reg_wdata_o),
      .stall_o     (stall_o),
      .misalign_o  (misalign_o),
      .bus_err_o   (bus_err_o),
      .dbus_req_o  (dbus_req_o),
      .dbus_we_o   (dbus_we_o),
      .dbus_addr_o (dbus_addr_o),
      .dbus_sel_o  (dbus_sel_o),
      .dbus_wdata_o(dbus_wdata_o),
      .dbus_rdata_i(dbus_rdata_i),
      .dbus_ack_i  (dbus_ack_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_st(int op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   function automatic bit ref_misalign(int op, logic [31:0] a);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
      if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_sel(int op, logic [31:0] a);
      int lo = int'(a % 4);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 32'(1 << lo);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return (lo >= 2) ? 32'd12 : 32'd3;
      return 32'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(int op, logic [31:0] d);
      if (op == OP_SB) return (d & 32'hFF) * 32'h0101_0101;
      if (op == OP_SH) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(int op, logic [31:0] a, logic [31:0] rd);
      logic [31:0] v, b, h;
      v = rd >> (8 * (a % 4));
      b = v & 32'hFF;
      h = v & 32'hFFFF;
      case (op)
         OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         OP_LHU:  return h;
         default: return rd;
      endcase
   endfunction

   // ---------------- stimulus tasks ----------------
   task automatic run_alu(input logic [4:0] wa, input logic [31:0] wd, input logic we);
      @(posedge clk); #1;
      mem_op_i = 4'(OP_NOP); reg_waddr_i = wa; reg_wdata_i = wd; reg_we_i = we;
      mem_addr_i = $urandom; mem_data_i = $urandom; mem_we_i = 1'b0;
      @(negedge clk);
      check("alu_waddr", 32'(reg_waddr_o), 32'(wa));
      check("alu_we",    32'(reg_we_o),    32'(we));
      check("alu_wdata", reg_wdata_o,      wd);
      check("alu_stall", 32'(stall_o),     32'd0);
      check("alu_req",   32'(dbus_req_o),  32'd0);
      check("alu_misal", 32'(misalign_o),  32'd0);
   endtask

   // w = wait cycles before ack; w >= TO means the ack never comes.
   task automatic run_mem(input int op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int w, input logic we);
      bit mis;
      int nreq;
      @(posedge clk); #1;
      mem_op_i = 4'(op); mem_addr_i = a; mem_data_i = d; mem_we_i = is_st(op);
      reg_we_i = we; reg_waddr_i = 5'($urandom); reg_wdata_i = $urandom;
      dbus_ack_i = 1'b0;
      mis = ref_misalign(op, a);
      @(negedge clk);
      check("misalign", 32'(misalign_o), 32'(mis));
      check("stall_first", 32'(stall_o), 32'(!mis));
      check("req_idle", 32'(dbus_req_o), 32'd0);
      check("wb_we_idle", 32'(reg_we_o), 32'd0);
      if (mis) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("mis_noreq", 32'(dbus_req_o), 32'd0);
         check("mis_stall", 32'(stall_o), 32'd0);
         return;
      end
      nreq = (w < TO) ? w + 1 : TO;
      for (int r = 0; r < nreq; r++) begin
         @(posedge clk); #1;
         dbus_ack_i   = (r == w) && (w < TO);
         dbus_rdata_i = (r == w) ? rd : $urandom;
         @(negedge clk);
         check("req_high", 32'(dbus_req_o), 32'd1);
         check("req_stall", 32'(stall_o), 32'd1);
         check("bus_addr", dbus_addr_o, a & 32'hFFFF_FFFC);
         check("bus_sel", 32'(dbus_sel_o), ref_sel(op, a));
         check("bus_we", 32'(dbus_we_o), 32'(is_st(op)));
         if (is_st(op)) check("bus_wdata", dbus_wdata_o, ref_wdata(op, d));
         check("wb_we_req", 32'(reg_we_o), 32'd0);
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      @(negedge clk);
      check("done_stall", 32'(stall_o), 32'd0);
      check("done_req", 32'(dbus_req_o), 32'd0);
      check("done_buserr", 32'(bus_err_o), 32'(w >= TO));
      if (is_st(op)) begin
         check("st_wb_we", 32'(reg_we_o), 32'd0);
      end else begin
         check("ld_wb_we", 32'(reg_we_o), 32'(we));
         check("ld_wdata", reg_wdata_o, (w >= TO) ? 32'd0 : ref_load(op, a, rd));
      end
   endtask

   initial begin
      // reset state
      #3;
      check("rst_req",   32'(dbus_req_o),  32'd0);
      check("rst_we",    32'(dbus_we_o),   32'd0);
      check("rst_addr",  dbus_addr_o,      32'd0);
      check("rst_sel",   32'(dbus_sel_o),  32'd0);
      check("rst_wdata", dbus_wdata_o,     32'd0);
      check("rst_buserr",32'(bus_err_o),   32'd0);
      check("rst_stall", 32'(stall_o),     32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed cases
      run_alu(5'd5, 32'h1234, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("alu_req_later", 32'(dbus_req_o), 32'd0);
      run_mem(OP_LB,  32'h103, 32'h0, 32'h80FF_0000, 2, 1'b1);
      run_mem(OP_LHU, 32'h102, 32'h0, 32'hBEEF_0000, 0, 1'b1);
      run_mem(OP_SB,  32'h101, 32'hAB, 32'h0, 1, 1'b1);
      run_mem(OP_SW,  32'h102, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);
      run_mem(OP_LW,  32'h200, 32'h0, 32'h1111_2222, TO, 1'b1);
      run_mem(OP_SH,  32'h302, 32'hCAFE_F00D, 32'h0, TO, 1'b1);

      // asynchronous reset in the middle of REQ
      @(posedge clk); #1;
      mem_op_i = 4'(OP_LW); mem_addr_i = 32'h400; reg_we_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_req", 32'(dbus_req_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", 32'(dbus_req_o), 32'd0);
      check("async_rst_sel", 32'(dbus_sel_o), 32'd0);
      mem_op_i = 4'(OP_NOP); reg_wdata_i = 32'h5555_AAAA;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'h7777_7777;
      @(negedge clk);
      check("late_ack_req", 32'(dbus_req_o), 32'd0);
      check("late_ack_stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      @(negedge clk);
      check("late_ack_err", 32'(bus_err_o), 32'd0);
      check("late_ack_req2", 32'(dbus_req_o), 32'd0);
      check("late_ack_wb", reg_wdata_o, 32'h5555_AAAA);
      run_mem(OP_LH, 32'h406, 32'h0, 32'h8001_0000, 1, 1'b1);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         int op;
         logic [31:0] a;
         op = int'($urandom_range(0, 8));
         a  = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
         if (op == OP_NOP)
            run_alu(5'($urandom), $urandom, 1'($urandom));
         else
            run_mem(op, a, $urandom, $urandom, int'($urandom_range(0, TO + 1)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
